pipe_stage_hs: RTL and testbench

- Next-generation pipeline register for the multi-issue core.
- Carries a bundle of LANES instruction/payload lanes between stages, each lane with its own valid bit.
- Uses a valid/ready handshake and an optional two-entry skid buffer, so the upstream ready is a registered signal.
- Adds whole-stage flush, per-lane (partial) flush and a stall hold. Generalises the fixed-width stall/flush stage register with its single issue-select partial clear.

---
 rtl/pipe_stage_hs.sv | 119 +++++++++++
 tb/tb_pipe_stage_hs.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// Multi-lane pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, whole-stage flush, per-lane flush with compaction and stall hold.
module pipe_stage_hs #(
    parameter int LANE_WIDTH = 32,
    parameter int LANES      = 2,
    parameter bit SKID       = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [LANES-1:0]            flush_lane_mask,
    input  logic [LANES-1:0]            in_valid,
    input  logic [LANES*LANE_WIDTH-1:0] in_data,
    output logic                        in_ready,
    output logic [LANES-1:0]            out_valid,
    output logic [LANES*LANE_WIDTH-1:0] out_data,
    input  logic                        out_ready,
    output logic [1:0]                  occupancy
);
    localparam int DW = LANES * LANE_WIDTH;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t state, state_nxt;

    logic [LANES-1:0] m_valid, s_valid, m_valid_nxt, s_valid_nxt;
    logic [DW-1:0]    m_data, s_data, m_data_nxt, s_data_nxt;
    logic [LANES-1:0] m_keep_v, s_keep_v;
    logic [DW-1:0]    m_keep_d, s_keep_d, in_keep_d;
    logic             push, pop;

    // Clears the payload of every lane whose keep bit is 0.
    function automatic logic [DW-1:0] lane_zero(input logic [DW-1:0] d,
                                                input logic [LANES-1:0] keep);
        logic [DW-1:0] r;
        r = d;
        for (int k = 0; k < LANES; k++)
            if (!keep[k]) r[k*LANE_WIDTH +: LANE_WIDTH] = '0;
        return r;
    endfunction

    assign push = (|in_valid) & in_ready & ~flush;
    assign pop  = (|m_valid) & out_ready & ~stall;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // NOTE: the payload registers are reset as well because killed or empty lanes
    // must present zero data, including straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= '0;
            m_data  <= '0;
            s_valid <= '0;
            s_data  <= '0;
        end else begin
            m_valid <= m_valid_nxt;
            m_data  <= m_data_nxt;
            s_valid <= s_valid_nxt;
            s_data  <= s_data_nxt;
        end
    end

    // Popped M leaves whole; survivors are masked, compacted toward M, then the push lands.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        m_valid_nxt = '0;
        m_data_nxt  = '0;
        s_valid_nxt = '0;
        s_data_nxt  = '0;
        m_keep_v    = pop ? '0 : (m_valid & ~flush_lane_mask);
        s_keep_v    = SKID ? (s_valid & ~flush_lane_mask) : '0;
        m_keep_d    = lane_zero(m_data, m_keep_v);
        s_keep_d    = lane_zero(s_data, s_keep_v);
        in_keep_d   = lane_zero(in_data, in_valid);

        if (!flush) begin
            if (|m_keep_v) begin
                m_valid_nxt = m_keep_v;
                m_data_nxt  = m_keep_d;
                if (|s_keep_v) begin
                    s_valid_nxt = s_keep_v;
                    s_data_nxt  = s_keep_d;
                end else if (push && SKID) begin
                    s_valid_nxt = in_valid;
                    s_data_nxt  = in_keep_d;
                end
            end else if (|s_keep_v) begin
                m_valid_nxt = s_keep_v;
                m_data_nxt  = s_keep_d;
                if (push) begin
                    s_valid_nxt = in_valid;
                    s_data_nxt  = in_keep_d;
                end
            end else if (push) begin
                m_valid_nxt = in_valid;
                m_data_nxt  = in_keep_d;
            end
        end

        if (|s_valid_nxt)      state_nxt = TWO;
        else if (|m_valid_nxt) state_nxt = ONE;
        else                   state_nxt = EMPTY;
    end

    always_comb begin
        if (SKID) in_ready = (state != TWO);
        else      in_ready = ~(|m_valid) | (out_ready & ~stall);
        occupancy = state;
        out_valid = m_valid;
        out_data  = m_data;
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: directed scenarios plus randomized traffic on a
// SKID=1 and a SKID=0 instance, both checked against a queue-based reference model.
module tb_pipe_stage_hs;
    localparam int W  = 32;
    localparam int L  = 2;
    localparam int DW = L * W;

    typedef struct {
        logic [L-1:0]  v;
        logic [DW-1:0] d;
    } bundle_t;
    typedef bundle_t bq_t[$];

    localparam logic [DW-1:0] A = {32'hA1A1_0001, 32'hA0A0_0000};
    localparam logic [DW-1:0] B = {32'hB1B1_0001, 32'hB0B0_0000};
    localparam logic [DW-1:0] C = {32'hC1C1_0001, 32'hC0C0_0000};

    logic clk, rst_n;
    logic stall, flush, out_ready, in_ready;
    logic [L-1:0] mask, in_valid, out_valid;
    logic [DW-1:0] in_data, out_data;
    logic [1:0] occupancy;

    logic stall0, flush0, out_ready0, in_ready0;
    logic [L-1:0] mask0, in_valid0, out_valid0;
    logic [DW-1:0] in_data0, out_data0;
    logic [1:0] occupancy0;

    int tests_run = 0;
    int tests_failed = 0;
    bq_t mq, mq0;

    pipe_stage_hs #(.LANE_WIDTH(W), .LANES(L), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_lane_mask(mask),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy));

    pipe_stage_hs #(.LANE_WIDTH(W), .LANES(L), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall0), .flush(flush0), .flush_lane_mask(mask0),
        .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
        .occupancy(occupancy0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] zero_lanes(logic [L-1:0] v, logic [DW-1:0] d);
        for (int k = 0; k < L; k++) if (!v[k]) d[k*W +: W] = '0;
        return d;
    endfunction

    // Stage as an ordered list of bundles: pop the head, mask the rest, drop empties, append.
    function automatic bq_t model_next(bq_t q, logic rdy, logic st, logic fl, logic [L-1:0] m,
                                       logic [L-1:0] iv, logic [DW-1:0] id, logic ordy);
        bq_t r;
        bundle_t e;
        if (fl) return r;
        if (q.size() > 0 && ordy && !st) void'(q.pop_front());
        foreach (q[i]) begin
            e.v = q[i].v & ~m;
            e.d = zero_lanes(e.v, q[i].d);
            if (|e.v) r.push_back(e);
        end
        if ((|iv) && rdy) begin
            e.v = iv;
            e.d = zero_lanes(iv, id);
            r.push_back(e);
        end
        return r;
    endfunction

    task automatic step();
        logic r1, r0;
        r1  = (mq.size() < 2);
        r0  = (mq0.size() == 0) || (out_ready0 && !stall0);
        mq  = model_next(mq, r1, stall, flush, mask, in_valid, in_data, out_ready);
        mq0 = model_next(mq0, r0, stall0, flush0, mask0, in_valid0, in_data0, out_ready0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = '0; in_data = '0; flush = 1'b0; mask = '0; stall = 1'b0; out_ready = 1'b1;
    endtask

    task automatic set_idle0();
        in_valid0 = '0; in_data0 = '0; flush0 = 1'b0; mask0 = '0; stall0 = 1'b0; out_ready0 = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        set_idle0();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        tests_run++; if (out_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_valid: got %b expected 00", out_valid); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", out_data); end
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready0: got %b expected 1", in_ready0); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        set_idle();
        in_valid = 2'b11; in_data = {32'h22, 32'h11};
        step();
        tests_run++; if (out_valid !== 2'b11) begin tests_failed++; $display("FAIL b2b_valid1: got %b expected 11", out_valid); end
        tests_run++; if (out_data !== {32'h22, 32'h11}) begin tests_failed++; $display("FAIL b2b_data1: got %h expected %h", out_data, {32'h22, 32'h11}); end
        tests_run++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin tests_failed++; $display("FAIL b2b_flow1: got ready=%b occ=%0d expected ready=1 occ=1", in_ready, occupancy); end
        in_data = {32'h44, 32'h33};
        step();
        tests_run++; if (out_data !== {32'h44, 32'h33}) begin tests_failed++; $display("FAIL b2b_data2: got %h expected %h", out_data, {32'h44, 32'h33}); end
        tests_run++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin tests_failed++; $display("FAIL b2b_flow2: got ready=%b occ=%0d expected ready=1 occ=1", in_ready, occupancy); end
        in_valid = '0;
        step();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 2'b00) begin tests_failed++; $display("FAIL b2b_drain: got occ=%0d valid=%b expected occ=0 valid=00", occupancy, out_valid); end
    endtask

    task automatic test_backpressure();
        set_idle();
        out_ready = 1'b0; in_valid = 2'b11; in_data = A;
        step();
        tests_run++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_first: got occ=%0d ready=%b expected occ=1 ready=1", occupancy, in_ready); end
        in_data = B;
        step();
        tests_run++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full: got occ=%0d ready=%b expected occ=2 ready=0", occupancy, in_ready); end
        tests_run++; if (out_data !== A) begin tests_failed++; $display("FAIL bp_head: got %h expected %h", out_data, A); end
        in_valid = '0; out_ready = 1'b1;
        step();
        tests_run++; if (out_data !== B || occupancy !== 2'd1 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_pop1: got data=%h occ=%0d ready=%b expected data=%h occ=1 ready=1", out_data, occupancy, in_ready, B); end
        step();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 2'b00) begin tests_failed++; $display("FAIL bp_pop2: got occ=%0d valid=%b expected occ=0 valid=00", occupancy, out_valid); end
    endtask

    task automatic test_full_flush();
        set_idle();
        out_ready = 1'b0; in_valid = 2'b11; in_data = A;
        step();
        in_data = B;
        step();
        flush = 1'b1; in_data = C;
        step();
        tests_run++; if (out_valid !== 2'b00 || occupancy !== 2'd0) begin tests_failed++; $display("FAIL flush_state: got valid=%b occ=%0d expected valid=00 occ=0", out_valid, occupancy); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL flush_data: got %h expected 0", out_data); end
        flush = 1'b0; in_valid = '0;
        step();
        tests_run++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_drop: got occ=%0d ready=%b expected occ=0 ready=1", occupancy, in_ready); end
    endtask

    task automatic test_partial_flush();
        set_idle();
        out_ready = 1'b0; in_valid = 2'b01; in_data = {32'hDEAD_0001, 32'h55};
        step();
        tests_run++; if (out_valid !== 2'b01 || out_data !== {32'h0, 32'h55}) begin tests_failed++; $display("FAIL pf_empty_lane: got valid=%b data=%h expected valid=01 data=%h", out_valid, out_data, {32'h0, 32'h55}); end
        in_valid = 2'b11; in_data = {32'h66, 32'h77};
        step();
        tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL pf_fill: got occ=%0d expected 2", occupancy); end
        in_valid = '0; mask = 2'b01;
        step();
        tests_run++; if (out_valid !== 2'b10 || occupancy !== 2'd1) begin tests_failed++; $display("FAIL pf_compact: got valid=%b occ=%0d expected valid=10 occ=1", out_valid, occupancy); end
        tests_run++; if (out_data !== {32'h66, 32'h0}) begin tests_failed++; $display("FAIL pf_data: got %h expected %h", out_data, {32'h66, 32'h0}); end
        mask = '0; flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_stall();
        set_idle();
        out_ready = 1'b0; in_valid = 2'b11; in_data = A;
        step();
        stall = 1'b1; out_ready = 1'b1; in_data = C;
        step();
        tests_run++; if (occupancy !== 2'd2 || out_data !== A) begin tests_failed++; $display("FAIL stall_hold: got occ=%0d data=%h expected occ=2 data=%h", occupancy, out_data, A); end
        stall = 1'b0; in_valid = '0;
        step();
        tests_run++; if (occupancy !== 2'd1 || out_data !== C) begin tests_failed++; $display("FAIL stall_release: got occ=%0d data=%h expected occ=1 data=%h", occupancy, out_data, C); end
        step();
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL stall_drain: got occ=%0d expected 0", occupancy); end
    endtask

    task automatic test_async_reset();
        set_idle();
        out_ready = 1'b0; in_valid = 2'b11; in_data = A;
        step();
        in_data = B;
        step();
        tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL ar_pre: got occ=%0d expected 2", occupancy); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 2'b00 || occupancy !== 2'd0) begin tests_failed++; $display("FAIL ar_clear: got valid=%b occ=%0d expected valid=00 occ=0", out_valid, occupancy); end
        tests_run++; if (in_ready !== 1'b1 || out_data !== '0) begin tests_failed++; $display("FAIL ar_ready: got ready=%b data=%h expected ready=1 data=0", in_ready, out_data); end
        mq.delete();
        mq0.delete();
        set_idle();
        #1 rst_n = 1'b1;
    endtask

    task automatic test_skid0();
        set_idle0();
        out_ready0 = 1'b0;
        #1;
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("FAIL s0_empty_ready: got %b expected 1", in_ready0); end
        in_valid0 = 2'b11; in_data0 = A;
        step();
        tests_run++; if (out_valid0 !== 2'b11 || occupancy0 !== 2'd1 || in_ready0 !== 1'b0) begin tests_failed++; $display("FAIL s0_store: got valid=%b occ=%0d ready=%b expected valid=11 occ=1 ready=0", out_valid0, occupancy0, in_ready0); end
        in_valid0 = '0; out_ready0 = 1'b1;
        #1;
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("FAIL s0_comb_ready: got %b expected 1", in_ready0); end
        stall0 = 1'b1;
        #1;
        tests_run++; if (in_ready0 !== 1'b0) begin tests_failed++; $display("FAIL s0_stall_ready: got %b expected 0", in_ready0); end
        stall0 = 1'b0; in_valid0 = 2'b11; in_data0 = B;
        step();
        tests_run++; if (out_data0 !== B || occupancy0 !== 2'd1) begin tests_failed++; $display("FAIL s0_replace: got data=%h occ=%0d expected data=%h occ=1", out_data0, occupancy0, B); end
        in_valid0 = '0;
        step();
        tests_run++; if (occupancy0 !== 2'd0) begin tests_failed++; $display("FAIL s0_drain: got occ=%0d expected 0", occupancy0); end
    endtask

    task automatic test_random();
        logic [L-1:0]  ev, ev0;
        logic [DW-1:0] ed, ed0;
        logic          er0;
        for (int c = 0; c < 3000; c++) begin
            in_valid   = L'($urandom);
            in_data    = {$urandom, $urandom};
            out_ready  = ((c / 64) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            stall      = ($urandom % 8 == 0);
            flush      = ($urandom % 40 == 0);
            mask       = ($urandom % 6 == 0) ? L'($urandom) : '0;
            in_valid0  = L'($urandom);
            in_data0   = {$urandom, $urandom};
            out_ready0 = ($urandom % 3 != 0);
            stall0     = ($urandom % 8 == 0);
            flush0     = ($urandom % 40 == 0);
            mask0      = ($urandom % 6 == 0) ? L'($urandom) : '0;
            #1;
            er0 = (mq0.size() == 0) || (out_ready0 && !stall0);
            tests_run++; if (in_ready !== (mq.size() < 2)) begin tests_failed++; $display("FAIL rand_ready cycle %0d: got %b expected %b (occ model %0d)", c, in_ready, mq.size() < 2, mq.size()); end
            tests_run++; if (in_ready0 !== er0) begin tests_failed++; $display("FAIL rand_ready0 cycle %0d: got %b expected %b", c, in_ready0, er0); end
            step();
            ev  = (mq.size() > 0) ? mq[0].v : '0;
            ed  = (mq.size() > 0) ? mq[0].d : '0;
            ev0 = (mq0.size() > 0) ? mq0[0].v : '0;
            ed0 = (mq0.size() > 0) ? mq0[0].d : '0;
            tests_run++; if (occupancy !== 2'(mq.size())) begin tests_failed++; $display("FAIL rand_occ cycle %0d: got %0d expected %0d", c, occupancy, mq.size()); end
            tests_run++; if (out_valid !== ev || out_data !== ed) begin tests_failed++; $display("FAIL rand_out cycle %0d: got %b/%h expected %b/%h", c, out_valid, out_data, ev, ed); end
            tests_run++; if (occupancy0 !== 2'(mq0.size())) begin tests_failed++; $display("FAIL rand_occ0 cycle %0d: got %0d expected %0d", c, occupancy0, mq0.size()); end
            tests_run++; if (out_valid0 !== ev0 || out_data0 !== ed0) begin tests_failed++; $display("FAIL rand_out0 cycle %0d: got %b/%h expected %b/%h", c, out_valid0, out_data0, ev0, ed0); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_full_flush();
        test_partial_flush();
        test_stall();
        test_async_reset();
        test_skid0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
